// File: rtl/aes_encipher_block.sv
// Iterative AES-128/AES-256 encipher round engine.
// The S-box is external: sboxw goes out, new_sboxw comes back in the same cycle.
module aes_encipher_block #(
    parameter logic [3:0] AES128_ROUNDS = 4'ha,
    parameter logic [3:0] AES256_ROUNDS = 4'he
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         next,
    input  logic         keylen,
    output logic [3:0]   round,
    input  logic [127:0] round_key,
    output logic [31:0]  sboxw,
    input  logic [31:0]  new_sboxw,
    input  logic [127:0] block,
    output logic [127:0] new_block,
    output logic         ready
);

    typedef enum logic [1:0] {IDLE, INIT, SBOX, MAIN} state_t;

    state_t         fsm_q;
    logic [127:0]   state_q;
    logic [3:0]     round_ctr_q;
    logic [1:0]     sword_ctr_q;
    logic           keylen_q;
    logic           ready_q;

    logic [3:0]     num_rounds;
    logic [127:0]   shifted;
    logic [127:0]   main_d;
    logic [127:0]   final_d;
    logic [127:0]   sub_d;

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [31:0] mix_word(input logic [31:0] w);
        logic [7:0] b0, b1, b2, b3;
        b0 = w[31:24];
        b1 = w[23:16];
        b2 = w[15:8];
        b3 = w[7:0];
        return {xtime(b0) ^ xtime(b1) ^ b1 ^ b2 ^ b3,
                b0 ^ xtime(b1) ^ xtime(b2) ^ b2 ^ b3,
                b0 ^ b1 ^ xtime(b2) ^ xtime(b3) ^ b3,
                xtime(b0) ^ b0 ^ b1 ^ b2 ^ xtime(b3)};
    endfunction

    // Column c, row r of the result comes from column (c+r) mod 4, row r.
    function automatic logic [127:0] shift_rows(input logic [127:0] s);
        logic [127:0] o;
        o = '0;
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) begin
                o[127 - 32*c - 8*r -: 8] = s[127 - 32*((c + r) % 4) - 8*r -: 8];
            end
        end
        return o;
    endfunction

    assign num_rounds = keylen_q ? AES256_ROUNDS : AES128_ROUNDS;
    assign shifted    = shift_rows(state_q);
    assign final_d    = shifted ^ round_key;
    assign main_d     = {mix_word(shifted[127:96]), mix_word(shifted[95:64]),
                         mix_word(shifted[63:32]),  mix_word(shifted[31:0])} ^ round_key;

    always_comb begin
        sboxw = 32'h0;
        sub_d = state_q;
        if (fsm_q == SBOX) begin
            case (sword_ctr_q)
                2'd0: begin sboxw = state_q[127:96]; sub_d[127:96] = new_sboxw; end
                2'd1: begin sboxw = state_q[95:64];  sub_d[95:64]  = new_sboxw; end
                2'd2: begin sboxw = state_q[63:32];  sub_d[63:32]  = new_sboxw; end
                default: begin sboxw = state_q[31:0]; sub_d[31:0] = new_sboxw; end
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            fsm_q       <= IDLE;
            state_q     <= '0;
            round_ctr_q <= '0;
            sword_ctr_q <= '0;
            keylen_q    <= 1'b0;
            ready_q     <= 1'b1;
        end else begin
            case (fsm_q)
                IDLE: begin
                    if (next) begin
                        round_ctr_q <= '0;
                        keylen_q    <= keylen;
                        ready_q     <= 1'b0;
                        fsm_q       <= INIT;
                    end
                end
                INIT: begin
                    state_q     <= block ^ round_key;
                    round_ctr_q <= 4'd1;
                    sword_ctr_q <= '0;
                    fsm_q       <= SBOX;
                end
                SBOX: begin
                    state_q     <= sub_d;
                    sword_ctr_q <= sword_ctr_q + 2'd1;
                    if (sword_ctr_q == 2'd3) fsm_q <= MAIN;
                end
                MAIN: begin
                    sword_ctr_q <= '0;
                    if (round_ctr_q < num_rounds) begin
                        state_q     <= main_d;
                        round_ctr_q <= round_ctr_q + 4'd1;
                        fsm_q       <= SBOX;
                    end else begin
                        // Final round: no MixColumns, round_ctr parks at num_rounds.
                        state_q <= final_d;
                        ready_q <= 1'b1;
                        fsm_q   <= IDLE;
                    end
                end
                default: fsm_q <= IDLE;
            endcase
        end
    end

    assign round     = round_ctr_q;
    assign new_block = state_q;
    assign ready     = ready_q;

endmodule

// File: doc/aes_encipher_block.md
Name: aes_encipher_block

Overview:
Iterative AES encipher datapath and control for AES-128 and AES-256. It is the forward-direction counterpart of the decipher round engine and uses the same keymem round_key interface and the same word-serial S-box scheme. The S-box is not instantiated inside this block. It is reached through an exported 32-bit port pair so the core can share one aes_sbox with the key expansion. Each round runs SubBytes one word per cycle, then one cycle of ShiftRows, MixColumns and AddRoundKey; the final round omits MixColumns.

Parameters:
AES128_ROUNDS, 4'ha, round count for keylen=0
AES256_ROUNDS, 4'he, round count for keylen=1

Ports:
clk  in  1  system clock, rising edge
reset  in  1  asynchronous, active-high reset
next  in  1  start pulse; sampled only in IDLE
keylen  in  1  0=AES-128, 1=AES-256; latched when next is accepted
round  out  4  round-key index requested from keymem (round_ctr_reg)
round_key  in  128  round key for index `round`, valid in the same cycle
sboxw  out  32  word to substitute; combinational
new_sboxw  in  32  S-box(sboxw), combinational return, same cycle
block  in  128  plaintext, byte 0 in [127:120]
new_block  out  128  state registers {w0,w1,w2,w3}; ciphertext when ready=1
ready  out  1  high when idle or result valid

Behaviour:
- Reset values: state w0..w3=0, round_ctr=0, sword_ctr=0, keylen_reg=0, ready=1, FSM=IDLE. Reset asserted mid-operation aborts the operation, returns to these values, and the partial result is discarded.
- FSM states: IDLE, INIT, SBOX, MAIN.
- IDLE:
  - next=1: round_ctr:=0, keylen_reg:=keylen, ready:=0, go to INIT.
  - next=0: hold all state; new_block holds the last result.
- INIT (1 cycle):
  - state := block ^ round_key, using round=0.
  - round_ctr:=1, sword_ctr:=0, go to SBOX.
  - block must be valid during this cycle.
- SBOX (4 cycles):
  - sboxw = word[sword_ctr]; that word := new_sboxw; sword_ctr++.
  - When sword_ctr==3, go to MAIN.
  - Outside SBOX, sboxw=0.
- MAIN (1 cycle), sword_ctr:=0:
  - round_ctr < num_rounds: state := AddRoundKey(MixColumns(ShiftRows(state)), round_key); round_ctr++; go to SBOX.
  - round_ctr == num_rounds (final): state := ShiftRows(state) ^ round_key; ready:=1; go to IDLE; round_ctr stays at num_rounds.
- ShiftRows: row r (byte r of each column word) rotates left by r columns. Output column c byte r = input column (c+r) mod 4 byte r.
- MixColumns per column word {b0,b1,b2,b3}:
  - mb0 = 2b0^3b1^b2^b3
  - mb1 = b0^2b1^3b2^b3
  - mb2 = b0^b1^2b2^3b3
  - mb3 = 3b0^b1^b2^2b3
  - GF(2^8) multiply uses xtime with 0x1b reduction.
- Latency, counted from the edge E0 that samples next in IDLE:
  - ready falls at E0.
  - Round r MAIN update occurs at E(1+5r).
  - ready rises at E(1+5N): E51 for AES-128, E71 for AES-256.
  - new_block is valid from that edge and stays stable until the next start.
- next asserted while busy (ready=0): ignored, with no effect on the running operation.
- next held high continuously: a new operation starts on the first IDLE cycle, one cycle after ready rises. ready stays high for exactly that one cycle, then falls.
- keylen changes during an operation: no effect, because keylen_reg is used.
- round is a pure function of round_ctr_reg. keymem sees round = 0,1,...,N in order.

Test Plan:
- FIPS-197 C.1 (bench keymem model plus sbox model): keylen=0, key 000102030405060708090a0b0c0d0e0f, block 00112233445566778899aabbccddeeff, pulse next -> ready rises 51 clocks later, new_block=69c4e0d86a7b0430d8cdb78070b4c55a.
- FIPS-197 C.3: keylen=1, key 000102...1e1f, same block -> ready after 71 clocks, new_block=8ea2b7ca516745bfeafc49904b496089.
- Sequence checks during the C.1 run:
  - round steps 0,1,1,1,1,1,2,... up to 10.
  - sboxw cycles w0..w3 in the SBOX state.
  - sboxw=0 in the other states.
- Busy/keylen robustness: pulse next again at clock 20 and toggle keylen mid-run -> result is still 69c4e0d8...c55a at clock 51 and no restart occurs.
- Reset mid-operation: assert reset at clock 30 -> immediately ready=1, new_block=0, round=0; a following C.1 run gives the correct result.
- Back-to-back: next held high across two AES-128 ops with different blocks -> both results correct; ready is high for exactly one cycle between them.
